// File: rtl/envelope_pkg.sv
// Shared widths, ADSR state encoding and full-scale helper for envelope_shaper.
package envelope_pkg;

  localparam int BITSIZE  = 24;
  localparam int ENVSIZE  = 16;
  localparam int PRODSIZE = BITSIZE + ENVSIZE + 1;

  typedef enum logic [2:0] {
    ENV_IDLE    = 3'd0,
    ENV_ATTACK  = 3'd1,
    ENV_DECAY   = 3'd2,
    ENV_SUSTAIN = 3'd3,
    ENV_RELEASE = 3'd4
  } env_state_t;

  function automatic logic [ENVSIZE-1:0] env_max();
    return {ENVSIZE{1'b1}};
  endfunction

  localparam logic [ENVSIZE-1:0] ENV_MAX = env_max();

endpackage

// File: rtl/envelope_shaper_if.sv
// Audio sample path between the sine generator, the envelope stage and i2s_tx.
interface envelope_shaper_if;
  import envelope_pkg::*;

  logic [BITSIZE-1:0] sample_in;
  logic [BITSIZE-1:0] sample_out;
  logic               out_valid;

  modport master (output sample_in, input sample_out, input out_valid);
  modport slave  (input sample_in, output sample_out, output out_valid);

endinterface

// File: rtl/envelope_shaper_sync_edge.sv
// Two-flop synchronizer with a registered rising-edge pulse.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], async_in};
      prev_q <= sync_q[1];
      rise   <= sync_q[1] & ~prev_q;
    end
  end

  assign sync_out = sync_q[1];

endmodule

// File: rtl/envelope_shaper.sv
// Per-frame ADSR envelope applied to the generator sample ahead of i2s_tx.
// Build option ENVELOPE_EXP_RELEASE_EN selects an exponential release curve.
module envelope_shaper
  import envelope_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lrclk,
  input  logic               gate,
  input  logic [ENVSIZE-1:0] attack_step,
  input  logic [ENVSIZE-1:0] decay_step,
  input  logic [ENVSIZE-1:0] release_step,
  input  logic [ENVSIZE-1:0] sustain_level,
  envelope_shaper_if.slave   audio,
  output logic [2:0]         env_state
);

  // state   | meaning
  // IDLE    | silent, waiting for gate
  // ATTACK  | ramping up by attack_step toward ENV_MAX
  // DECAY   | ramping down by decay_step toward sustain_level
  // SUSTAIN | holding sustain_level (follows live changes)
  // RELEASE | ramping down to zero after gate drops

  logic                      tick;
  logic                      lrclk_sync;
  logic [1:0]                gate_sync;
  logic                      gate_s;
  env_state_t                state;
  logic [ENVSIZE-1:0]        env;
  logic signed [BITSIZE-1:0] sample_hold;
  logic                      calc_en;
  logic [ENVSIZE:0]          attack_sum;
  logic signed [ENVSIZE:0]   decay_diff;
  logic [ENVSIZE:0]          rel_dec;
  logic signed [PRODSIZE-1:0] product;

  sync_edge u_lrclk_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (lrclk),
    .sync_out (lrclk_sync),
    .rise     (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gate_sync <= 2'b00;
    else        gate_sync <= {gate_sync[0], gate};
  end

  assign gate_s = gate_sync[1];

  always_comb begin
    attack_sum = {1'b0, env} + {1'b0, attack_step};
    decay_diff = $signed({1'b0, env}) - $signed({1'b0, decay_step});
`ifdef ENVELOPE_EXP_RELEASE_EN
    rel_dec    = {1'b0, env >> release_step[3:0]} + {{ENVSIZE{1'b0}}, 1'b1};
`else
    rel_dec    = {1'b0, release_step};
`endif
    // Unsigned env zero-extended so full scale stays positive.
    product    = sample_hold * $signed({1'b0, env});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ENV_IDLE;
      env              <= '0;
      sample_hold      <= '0;
      calc_en          <= 1'b0;
      audio.sample_out <= '0;
      audio.out_valid  <= 1'b0;
      env_state        <= ENV_IDLE;
    end else begin
      calc_en         <= tick;
      audio.out_valid <= calc_en;
      if (calc_en)
        audio.sample_out <= product[ENVSIZE +: BITSIZE];

      if (tick) begin
        sample_hold <= $signed(audio.sample_in);
        case (state)
          ENV_IDLE: begin
            if (gate_s) begin
              state     <= ENV_ATTACK;
              env_state <= ENV_ATTACK;
            end
          end
          ENV_ATTACK: begin
            if (!gate_s) begin
              state     <= ENV_RELEASE;
              env_state <= ENV_RELEASE;
            end else if (attack_sum >= {1'b0, ENV_MAX}) begin
              env       <= ENV_MAX;
              state     <= ENV_DECAY;
              env_state <= ENV_DECAY;
            end else begin
              env <= attack_sum[ENVSIZE-1:0];
            end
          end
          ENV_DECAY: begin
            if (!gate_s) begin
              state     <= ENV_RELEASE;
              env_state <= ENV_RELEASE;
            end else if (decay_diff <= $signed({1'b0, sustain_level})) begin
              env       <= sustain_level;
              state     <= ENV_SUSTAIN;
              env_state <= ENV_SUSTAIN;
            end else begin
              env <= decay_diff[ENVSIZE-1:0];
            end
          end
          ENV_SUSTAIN: begin
            if (!gate_s) begin
              state     <= ENV_RELEASE;
              env_state <= ENV_RELEASE;
            end else begin
              env <= sustain_level;
            end
          end
          ENV_RELEASE: begin
            // Retrigger resumes attack from the current level.
            if (gate_s) begin
              state     <= ENV_ATTACK;
              env_state <= ENV_ATTACK;
            end else if ({1'b0, env} <= rel_dec) begin
              env       <= '0;
              state     <= ENV_IDLE;
              env_state <= ENV_IDLE;
            end else begin
              env <= env - rel_dec[ENVSIZE-1:0];
            end
          end
          default: begin
            state     <= ENV_IDLE;
            env_state <= ENV_IDLE;
            env       <= '0;
          end
        endcase
      end
    end
  end

  logic unused_lrclk;
  assign unused_lrclk = lrclk_sync;

endmodule

// File: tb/tb_envelope_shaper.sv
// Directed ADSR sequence check for envelope_shaper with hand-computed outputs.
module tb_envelope_shaper;
  import envelope_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lrclk = 1'b0;
  logic        gate = 1'b0;
  logic [15:0] attack_step = '0;
  logic [15:0] decay_step = '0;
  logic [15:0] release_step = '0;
  logic [15:0] sustain_level = '0;
  logic [2:0]  env_state;

  envelope_shaper_if aif ();

  envelope_shaper dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .lrclk         (lrclk),
    .gate          (gate),
    .attack_step   (attack_step),
    .decay_step    (decay_step),
    .release_step  (release_step),
    .sustain_level (sustain_level),
    .audio         (aif),
    .env_state     (env_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One audio frame: raise lrclk, wait a bounded time for out_valid, check results.
  task automatic frame(input string tag, input logic [2:0] exp_state, input logic [23:0] exp_out);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    lrclk = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (aif.out_valid) seen = 1'b1;
    end
    check({tag, " valid"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      check({tag, " state"}, {29'd0, env_state}, {29'd0, exp_state});
      check({tag, " out"}, {8'd0, aif.sample_out}, {8'd0, exp_out});
      @(negedge clk);
      check({tag, " pulse"}, {31'd0, aif.out_valid}, 32'd0);
    end
    repeat (3) @(negedge clk);
    lrclk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e;
    aif.sample_in = 24'h400000;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      lrclk = ~lrclk;
      check("rst valid", {31'd0, aif.out_valid}, 32'd0);
    end
    check("rst out", {8'd0, aif.sample_out}, 32'd0);
    check("rst state", {29'd0, env_state}, 32'd0);
    @(negedge clk);
    lrclk = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    attack_step   = 16'h4000;
    decay_step    = 16'h1000;
    sustain_level = 16'h8000;
    release_step  = 16'h3000;
    gate          = 1'b1;
    repeat (4) @(negedge clk);

    frame("atk0", 3'd1, 24'h000000);
    frame("atk1", 3'd1, 24'h100000);
    frame("atk2", 3'd1, 24'h200000);
    frame("atk3", 3'd1, 24'h300000);
    aif.sample_in = 24'h800000;
    frame("peak_neg", 3'd2, 24'h800080);
    decay_step    = 16'h0000;
    aif.sample_in = 24'h7FFFFF;
    frame("peak_pos", 3'd2, 24'h7FFF7F);
    decay_step    = 16'h1000;
    aif.sample_in = 24'h400000;
    for (int i = 1; i <= 7; i++) begin
      e = 32'hFFFF - 32'(i) * 32'h1000;
      frame("decay", 3'd2, 24'(e << 6));
    end
    frame("sus_enter", 3'd3, 24'h200000);
    sustain_level = 16'h6000;
    frame("sus_track", 3'd3, 24'h180000);
    sustain_level = 16'h8000;
    frame("sus_back", 3'd3, 24'h200000);

    gate = 1'b0;
`ifdef ENVELOPE_EXP_RELEASE_EN
    release_step = 16'h0001;
    frame("exp0", 3'd4, 24'h200000);
    e = 32'h3FFF;
    for (int i = 0; i < 14; i++) begin
      frame("exp", 3'd4, 24'(e << 6));
      e = e >> 1;
    end
    frame("exp_end", 3'd0, 24'h000000);
`else
    frame("rel0", 3'd4, 24'h200000);
    frame("rel1", 3'd4, 24'h140000);
    gate = 1'b1;
    frame("retrig", 3'd1, 24'h140000);
    frame("retrig_atk", 3'd1, 24'h240000);
    gate = 1'b0;
    frame("rel2", 3'd4, 24'h240000);
    frame("rel3", 3'd4, 24'h180000);
    frame("rel4", 3'd4, 24'h0C0000);
    frame("rel_end", 3'd0, 24'h000000);
`endif
    frame("idle", 3'd0, 24'h000000);

    gate = 1'b1;
    frame("mr_atk0", 3'd1, 24'h000000);
    frame("mr_atk1", 3'd1, 24'h100000);
    @(negedge clk);
    lrclk = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mr out", {8'd0, aif.sample_out}, 32'd0);
    check("mr state", {29'd0, env_state}, 32'd0);
    check("mr valid", {31'd0, aif.out_valid}, 32'd0);
    repeat (3) @(negedge clk);
    lrclk = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    frame("mr_post", 3'd1, 24'h000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
